uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver; sits directly downstream of uart_tx and consumes its `tx` line.
- Samples an 11-bit frame: start(0), 8 data bits MSB first, parity, stop(1). Bit period is 14 cycles of the 3.125 MHz clock.
- Delivers the recovered byte, the received parity bit and error flags, with a one-cycle completion pulse.
- Used on loopback and host-link paths to return colour-sensor data.

Parameters:
- CLKS_PER_BIT, 14, clock cycles per serial bit.
- SAMPLE_POINT, 7, cycle index within a bit period at which rx is sampled (0..CLKS_PER_BIT-1).

Ports:
- clk_3125  input  1  3.125 MHz system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idle high.
- parity_type  input  1  0 = even parity (parity bit = ^data), 1 = odd (parity bit = ~^data).
- rx_msg  output  8  last received byte; first serial data bit lands in rx_msg[7].
- rx_parity  output  1  parity bit as received on the line.
- rx_complete  output  1  one-cycle pulse when a frame finishes.
- parity_err  output  1  received parity != parity computed from rx_msg and parity_type.
- frame_err  output  1  stop bit sampled low.

Behaviour:
- One clock; reset asynchronous, active-low.
- Reset (async assert, any state): state=IDLE, counters=0, rx_msg=8'h00, rx_parity=0, rx_complete=0, parity_err=0, frame_err=0.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- Cycle counter cnt runs 0..CLKS_PER_BIT-1 and wraps. Bit index bit_idx runs 0..7 in DATA.
- IDLE:
  - On the first cycle rx is sampled 0, go to START with cnt=0. That cycle is cycle 0 of the frame.
- START:
  - At cnt==SAMPLE_POINT, if rx==1 the start was a glitch: return to IDLE, no outputs change.
  - Otherwise continue; on the cnt wrap go to DATA.
- DATA:
  - At cnt==SAMPLE_POINT, shift rx into an internal shift register. First bit ends in bit 7.
  - On the wrap after bit_idx==7, go to PARITY.
- PARITY:
  - Sample at SAMPLE_POINT into an internal register; go to STOP on the wrap.
- STOP:
  - Sample at SAMPLE_POINT.
  - At cnt==CLKS_PER_BIT-1 (frame cycle 11*CLKS_PER_BIT-1 = 153), update in the same edge: rx_msg, rx_parity, parity_err, frame_err, and set rx_complete=1.
  - Next state: IDLE if the stop sample was 1, WAIT_IDLE if it was 0.
- WAIT_IDLE:
  - Hold until rx==1, then go to IDLE. No start is detected while rx stays low (break condition).
- rx_complete is high for exactly one cycle per frame.
- rx_msg, rx_parity and the error flags hold until the next rx_complete.
- Error handling: a frame with an error still updates rx_msg and pulses rx_complete. Both errors can be set together.
- Back-to-back frames with a single idle-high cycle between them are received without loss. A new start is recognised on the cycle after the return to IDLE.
- parity_type is sampled at the STOP update edge; changing it mid-frame affects only that frame's parity_err.
- Reset mid-frame: partial frame discarded; after release, wait in IDLE for a falling edge.
- Latency: rx_complete asserts 153 cycles after the first low sample of the start bit (155 when RX_SYNC_EN is defined).

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx passes through a two-flop synchronizer; both flops reset to 1. All sampling uses the synchronized signal, so every timing point shifts by +2 cycles.
- Undefined: rx is used directly; the source must be synchronous to clk_3125, e.g. straight from uart_tx.

Test Plan:
- Even parity, send 0xA5 (parity bit 0) at 14 cycles/bit → rx_complete pulses once 153 cycles after start; rx_msg=8'hA5, rx_parity=0, parity_err=0, frame_err=0.
- parity_type=1, send 0x3C with parity bit 1 → rx_msg=8'h3C, rx_parity=1, parity_err=0. Then send 0x3C with parity bit 0 → parity_err=1, rx_complete still pulses.
- rx low for 3 cycles, then high → no rx_complete; outputs unchanged; the next valid frame 0x5A is received correctly.
- Frame 0xFF with stop bit low, rx held low 40 more cycles, then high → frame_err=1; no new frame starts until rx goes high; the following frame 0x01 is received with frame_err=0.
- Ten back-to-back frames (0x00, 0x01, 0x80, 0xFF, 0x55, 0xAA, 0x0F, 0xF0, 0x3C, 0xC3), one idle cycle between them → ten rx_complete pulses, each rx_msg matching in order.
- Assert rst_n low at frame cycle 60 for 2 cycles → all outputs are 0 immediately (asynchronous). The partial frame produces no rx_complete; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 11-bit UART receiver (start, 8 data MSB first, parity, stop) at CLKS_PER_BIT clocks per bit.
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchronizer (all timing shifts by +2 cycles).
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | line idle, waiting for the first low sample of a start bit
// START      | inside start bit; mid-bit high sample means glitch -> IDLE
// DATA       | shifting in 8 data bits, first bit ends in shift_q[7]
// PARITY     | capturing the received parity bit
// STOP       | capturing stop bit; last cycle publishes the frame
// WAIT_IDLE  | stop bit was low (break); hold until line returns high

module uart_rx #(
    parameter int CLKS_PER_BIT = 14,
    parameter int SAMPLE_POINT = 7
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       rx_complete,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], rx};

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= sync_d;
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             stop_q, stop_d;
    logic [7:0]       rx_msg_q, rx_msg_d;
    logic             rx_parity_q, rx_parity_d;
    logic             rx_complete_q, rx_complete_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;

    logic             at_sample, at_wrap, stop_bit;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        at_sample = (cnt_q == CNT_SAMPLE);
        at_wrap   = (cnt_q == CNT_LAST);
        cnt_next  = at_wrap ? '0 : cnt_q + CNT_W'(1);
        stop_bit  = at_sample ? rx_s : stop_q;

        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        stop_d        = stop_q;
        rx_msg_d      = rx_msg_q;
        rx_parity_d   = rx_parity_q;
        rx_complete_d = 1'b0;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // The detecting cycle is cycle 0 of the start bit, so START begins at count 1.
                if (!rx_s) begin
                    state_d   = S_START;
                    cnt_d     = CNT_W'(1);
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                cnt_d = cnt_next;
                if (at_sample && rx_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_next;
                if (at_sample) shift_d = {shift_q[6:0], rx_s};
                if (at_wrap) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                cnt_d = cnt_next;
                if (at_sample) par_d = rx_s;
                if (at_wrap) state_d = S_STOP;
            end
            S_STOP: begin
                cnt_d = cnt_next;
                if (at_sample) stop_d = rx_s;
                if (at_wrap) begin
                    rx_msg_d      = shift_q;
                    rx_parity_d   = par_q;
                    // Even: expect ^data; odd: expect ~^data.
                    parity_err_d  = par_q ^ (^shift_q) ^ parity_type;
                    frame_err_d   = ~stop_bit;
                    rx_complete_d = 1'b1;
                    state_d       = stop_bit ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            stop_q        <= 1'b0;
            rx_msg_q      <= 8'h00;
            rx_parity_q   <= 1'b0;
            rx_complete_q <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            stop_q        <= stop_d;
            rx_msg_q      <= rx_msg_d;
            rx_parity_q   <= rx_parity_d;
            rx_complete_q <= rx_complete_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign rx_msg      = rx_msg_q;
    assign rx_parity   = rx_parity_q;
    assign rx_complete = rx_complete_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a queue-based reference model.
// Frame results are compared field-by-field and completion latency is checked per frame.

module tb_uart_rx;

    localparam int CPB = 14;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 155;
`else
    localparam int LAT = 153;
`endif

    typedef struct packed {
        logic [7:0] msg;
        logic       par;
        logic       perr;
        logic       ferr;
    } res_t;

    logic       clk_3125 = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       parity_type = 1'b0;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;
    logic       parity_err;
    logic       frame_err;

    uart_rx dut (
        .clk_3125   (clk_3125),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_type(parity_type),
        .rx_msg     (rx_msg),
        .rx_parity  (rx_parity),
        .rx_complete(rx_complete),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #160 clk_3125 = ~clk_3125;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    res_t got_q[$];
    int   got_cyc_q[$];
    res_t exp_q[$];
    int   exp_start_q[$];
    res_t last_res = '0;

    always @(posedge clk_3125) cyc++;

    always @(negedge clk_3125) begin
        if (rst_n && rx_complete) begin
            got_q.push_back({rx_msg, rx_parity, parity_err, frame_err});
            got_cyc_q.push_back(cyc);
        end
    end

    // Reference: parity error when total ones in data+parity bit does not have the requested oddness.
    function automatic res_t model(input logic [7:0] d, input logic p, input logic s, input logic pt);
        res_t r;
        int   ones;
        ones   = $countones(d) + (p ? 1 : 0);
        r.msg  = d;
        r.par  = p;
        r.ferr = !s;
        r.perr = ((ones % 2) == 1) != pt;
        return r;
    endfunction

    function automatic logic even_bit(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_3125);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic pt0, input logic pt1, input int hold_low, input int gap);
        logic [10:0] bits;
        bits = {1'b0, d, p, s};
        exp_q.push_back(model(d, p, s, pt1));
        exp_start_q.push_back(cyc);
        for (int c = 0; c < 11 * CPB; c++) begin
            rx = bits[10 - c / CPB];
            if (c == 2) parity_type = pt0;
            if (c == 70) parity_type = pt1;
            @(posedge clk_3125);
            #1;
        end
        if (hold_low > 0) begin
            rx = 1'b0;
            tick(hold_low);
        end
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if ({rx_msg, rx_parity, rx_complete, parity_err, frame_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got msg=%h par=%b cmp=%b perr=%b ferr=%b, expected all zero",
                     rx_msg, rx_parity, rx_complete, parity_err, frame_err);
        end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL basic_frame: got msg=%h par=%b perr=%b ferr=%b, expected msg=%h par=%b perr=%b ferr=%b",
                         g.msg, g.par, g.perr, g.ferr, e.msg, e.par, e.perr, e.ferr);
            end
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL basic_latency: got %0d cycles, expected %0d", lat, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    task automatic test_parity();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 0, 2);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2);
        // parity_type flips mid-frame; only the value at the stop edge matters
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL parity_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL parity_frame: got msg=%h par=%b perr=%b ferr=%b, expected msg=%h par=%b perr=%b ferr=%b",
                         g.msg, g.par, g.perr, g.ferr, e.msg, e.par, e.perr, e.ferr);
            end
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL parity_latency: got %0d cycles, expected %0d", lat, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    task automatic test_glitch();
        parity_type = 1'b0;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_no_pulse: got %0d pulses, expected 0", got_q.size());
        end
        n_checks++;
        if ({rx_msg, rx_parity, parity_err, frame_err} !== last_res) begin
            n_fail++;
            $display("FAIL glitch_hold: got msg=%h par=%b perr=%b ferr=%b, expected msg=%h par=%b perr=%b ferr=%b",
                     rx_msg, rx_parity, parity_err, frame_err,
                     last_res.msg, last_res.par, last_res.perr, last_res.ferr);
        end
        got_q.delete(); got_cyc_q.delete();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e || lat != LAT) begin
                n_fail++;
                $display("FAIL glitch_frame: got msg=%h perr=%b ferr=%b lat=%0d, expected msg=%h perr=%b ferr=%b lat=%0d",
                         g.msg, g.perr, g.ferr, lat, e.msg, e.perr, e.ferr, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    task automatic test_frame_err();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 40, 2);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL frame_err_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL frame_err_frame: got msg=%h par=%b perr=%b ferr=%b, expected msg=%h par=%b perr=%b ferr=%b",
                         g.msg, g.par, g.perr, g.ferr, e.msg, e.par, e.perr, e.ferr);
            end
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL frame_err_latency: got %0d cycles, expected %0d", lat, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [10];
        data = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
        for (int i = 0; i < 10; i++)
            send_frame(data[i], even_bit(data[i]), 1'b1, 1'b0, 1'b0, 0, 1);
        tick(2);
        n_checks++;
        if (got_q.size() != 10) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, expected 10", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e || lat != LAT) begin
                n_fail++;
                $display("FAIL b2b_frame: got msg=%h perr=%b ferr=%b lat=%0d, expected msg=%h perr=%b ferr=%b lat=%0d",
                         g.msg, g.perr, g.ferr, lat, e.msg, e.perr, e.ferr, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    task automatic test_random();
        int n_sent;
        n_sent = 20;
        for (int i = 0; i < n_sent; i++) begin
            logic [7:0] d;
            logic       p, s, pt0, pt1;
            int         hold;
            d    = 8'($urandom_range(0, 255));
            p    = 1'($urandom_range(0, 1));
            s    = ($urandom_range(0, 3) != 0);
            pt0  = 1'($urandom_range(0, 1));
            pt1  = 1'($urandom_range(0, 1));
            hold = s ? 0 : $urandom_range(0, 20);
            send_frame(d, p, s, pt0, pt1, hold, $urandom_range(1, 4));
        end
        n_checks++;
        if (got_q.size() != n_sent) begin
            n_fail++;
            $display("FAIL random_count: got %0d pulses, expected %0d", got_q.size(), n_sent);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e || lat != LAT) begin
                n_fail++;
                $display("FAIL random_frame: got msg=%h par=%b perr=%b ferr=%b lat=%0d, expected msg=%h par=%b perr=%b ferr=%b lat=%0d",
                         g.msg, g.par, g.perr, g.ferr, lat, e.msg, e.par, e.perr, e.ferr, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
        bits = {1'b0, 8'h96, 1'b0, 1'b1};
        for (int c = 0; c < 60; c++) begin
            rx = bits[10 - c / CPB];
            @(posedge clk_3125);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_msg, rx_parity, rx_complete, parity_err, frame_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got msg=%h par=%b cmp=%b perr=%b ferr=%b, expected all zero",
                     rx_msg, rx_parity, rx_complete, parity_err, frame_err);
        end
        tick(2);
        rx    = 1'b1;
        rst_n = 1'b1;
        tick(200);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_discard: got %0d pulses, expected 0", got_q.size());
        end
        got_q.delete(); got_cyc_q.delete();
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d pulses, expected 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g, e;
            int   lat;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = got_cyc_q.pop_front() - exp_start_q.pop_front() - 1;
            last_res = e;
            n_checks++;
            if (g !== e || lat != LAT) begin
                n_fail++;
                $display("FAIL reset_mid_frame: got msg=%h perr=%b ferr=%b lat=%0d, expected msg=%h perr=%b ferr=%b lat=%0d",
                         g.msg, g.perr, g.ferr, lat, e.msg, e.perr, e.ferr, LAT);
            end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete(); exp_start_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
